// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin arbiter merging ALU and load-unit writebacks onto one
// registered register-file write port, with a saturating conflict counter.
module rf_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          v0,
    input  logic [AW-1:0] a0,
    input  logic [DW-1:0] d0,
    output logic          rdy0,
    input  logic          v1,
    input  logic [AW-1:0] a1,
    input  logic [DW-1:0] d1,
    output logic          rdy1,
    input  logic          hold,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic [15:0]   conflict_cnt
);
    typedef enum logic {P0, P1} state_t;
    state_t state_q, state_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic [15:0]   conflict_q, conflict_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= P0;
        else     state_q <= state_d;
    end
    always_comb begin
        state_d = rdy0 ? P1 : rdy1 ? P0 : state_q;
    end
    // Grants depend only on valids, hold and priority, never on address/data.
    always_comb begin
        rdy0 = ~rst & ~hold & v0 & (~v1 | (state_q == P0));
        rdy1 = ~rst & ~hold & v1 & (~v0 | (state_q == P1));
    end
    // Writes to register 0 are accepted but suppressed at the output stage.
    always_comb begin
        wr_en_d    = (rdy0 & (a0 != '0)) | (rdy1 & (a1 != '0));
        wr_addr_d  = rdy0 ? a0 : rdy1 ? a1 : wr_addr_q;
        wr_data_d  = rdy0 ? d0 : rdy1 ? d1 : wr_data_q;
        conflict_d = (v0 & v1 & ~hold & (conflict_q != 16'hFFFF)) ? conflict_q + 16'd1 : conflict_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            conflict_q <= '0;
        end else begin
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            conflict_q <= conflict_d;
        end
    end
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign conflict_cnt = conflict_q;
endmodule
